// File: rtl/draw_scheduler_if.sv
// Pixel-port sharing bus for draw_scheduler: square/image requests from the
// game FSM, the image drawer's pixel stream, and the VGA pixel-write port.
interface draw_scheduler_if;
   // Square-draw request side
   logic       sqReq;
   logic [3:0] sqX;
   logic [3:0] sqY;
   logic       sqBoard;
   logic [2:0] sqColour;
   logic       sqFull;
   logic       sqDropped;
   // Image-draw request side
   logic       imgReq;
   logic [1:0] imgSel;
   // External image drawer
   logic       imgStart;
   logic [1:0] imgSelOut;
   logic [7:0] imgX;
   logic [6:0] imgY;
   logic [2:0] imgColour;
   logic       imgValid;
   logic       imgDone;
   // VGA pixel-write port
   logic [7:0] posXout;
   logic [6:0] posYout;
   logic [2:0] colourOut;
   logic       plotEn;
   logic       busy;

   // Environment side: game FSM, image drawer and VGA adapter together
   modport master (
      output sqReq, sqX, sqY, sqBoard, sqColour,
      output imgReq, imgSel,
      output imgX, imgY, imgColour, imgValid, imgDone,
      input  sqFull, sqDropped, imgStart, imgSelOut,
      input  posXout, posYout, colourOut, plotEn, busy
   );

   // Scheduler side
   modport slave (
      input  sqReq, sqX, sqY, sqBoard, sqColour,
      input  imgReq, imgSel,
      input  imgX, imgY, imgColour, imgValid, imgDone,
      output sqFull, sqDropped, imgStart, imgSelOut,
      output posXout, posYout, colourOut, plotEn, busy
   );
endinterface

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates the single VGA pixel-write port between queued
// 4x4 attack-cell square draws and full-screen image draws. Squares are
// expanded internally; image pixels are forwarded from the external drawer.
module draw_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int ORIGIN_X0  = 26,
   parameter int ORIGIN_X1  = 90,
   parameter int ORIGIN_Y   = 36,
   parameter int PITCH      = 5
) (
   input logic            clk,
   input logic            Reset,
   draw_scheduler_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   // Queue entry {board, x, y, colour}
   localparam int ENT_W = 12;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SQUARE = 2'd1,
      S_IMAGE  = 2'd2
   } state_t;

   state_t           r_state, w_next;

   logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
   logic [ENT_W-1:0] w_head;
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic             r_full, r_dropped;
   logic             w_push, w_pop, w_fifo_ne;

   logic             r_pend;
   logic [1:0]       r_sel;
   logic             r_last_img;
   logic             w_grant_sq, w_grant_img;

   logic [3:0]       r_cnt, r_wx, r_wy;
   logic             r_wboard;
   logic [2:0]       r_wcol;
   logic [8:0]       w_org_x, w_sum_x, w_sum_y;

   logic [7:0]       r_posx, w_posx;
   logic [6:0]       r_posy, w_posy;
   logic [2:0]       r_colour, w_colour;
   logic             r_plot, w_plot;
   logic             r_start, w_start;
   logic [1:0]       r_selout;
   logic             r_busy;

   // Advance a ring pointer, wrapping at the queue depth
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // True when a 9-bit pixel coordinate lands on the 160x120 screen
   function automatic logic on_screen(input logic [8:0] x, input logic [8:0] y);
      return (x <= 9'd159) && (y <= 9'd119);
   endfunction

   assign w_fifo_ne   = (r_count != '0);
   assign w_pop       = w_grant_sq;
   // A push into a full queue only succeeds when the head leaves this cycle
   assign w_push      = bus.sqReq && (!r_full || w_pop);
   assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_head      = r_mem[r_rd_ptr];

   // Pixel address of the current square cell, computed at 9 bits so
   // off-screen positions are detectable rather than wrapping
   assign w_org_x = r_wboard ? 9'(ORIGIN_X1) : 9'(ORIGIN_X0);
   assign w_sum_x = w_org_x + {7'd0, r_cnt[1:0]} + 9'(PITCH) * {5'd0, r_wx};
   assign w_sum_y = 9'(ORIGIN_Y) + {7'd0, r_cnt[3:2]} + 9'(PITCH) * {5'd0, r_wy};

   // State register
   always_ff @(posedge clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and grant decision; ties alternate against the last grant
   always_comb begin
      w_next      = r_state;
      w_grant_sq  = 1'b0;
      w_grant_img = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_grant_sq  = w_fifo_ne && (!r_pend || r_last_img);
            w_grant_img = r_pend && (!w_fifo_ne || !r_last_img);
            if (w_grant_sq)       w_next = S_SQUARE;
            else if (w_grant_img) w_next = S_IMAGE;
         end
         S_SQUARE: if (r_cnt == 4'd15) w_next = S_IDLE;
         S_IMAGE:  if (bus.imgDone)    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Next pixel-port values; held outputs keep their last value in IDLE
   always_comb begin
      w_posx   = r_posx;
      w_posy   = r_posy;
      w_colour = r_colour;
      w_plot   = 1'b0;
      w_start  = 1'b0;
      case (r_state)
         S_SQUARE: begin
            w_posx   = w_sum_x[7:0];
            w_posy   = w_sum_y[6:0];
            w_colour = r_wcol;
            w_plot   = on_screen(w_sum_x, w_sum_y);
         end
         S_IMAGE: begin
            w_posx   = bus.imgX;
            w_posy   = bus.imgY;
            w_colour = bus.imgColour;
            w_plot   = bus.imgValid;
         end
         default: w_start = w_grant_img;
      endcase
   end

   // Queue storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {bus.sqBoard, bus.sqX, bus.sqY, bus.sqColour};
   end

   // Queue pointers, occupancy, full flag and drop pulse
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count   <= w_count_nxt;
         r_full    <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
         r_dropped <= bus.sqReq && !w_push;
      end
   end

   // Image-pending flag, latest select, and round-robin memory
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_pend     <= 1'b0;
         r_sel      <= 2'd0;
         r_last_img <= 1'b1;
      end else begin
         if (w_grant_img) r_pend <= 1'b0;
         // A request arriving with the grant is kept for a later job
         if (bus.imgReq) begin
            r_pend <= 1'b1;
            r_sel  <= bus.imgSel;
         end
         if (w_grant_sq)       r_last_img <= 1'b0;
         else if (w_grant_img) r_last_img <= 1'b1;
      end
   end

   // Square working registers and pixel counter
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_cnt <= 4'd0;
      end else if (w_grant_sq) begin
         r_cnt <= 4'd0;
      end else if (r_state == S_SQUARE) begin
         r_cnt <= r_cnt + 4'd1;
      end
      if (w_grant_sq) begin
         r_wboard <= w_head[11];
         r_wx     <= w_head[10:7];
         r_wy     <= w_head[6:3];
         r_wcol   <= w_head[2:0];
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_posx   <= 8'd0;
         r_posy   <= 7'd0;
         r_colour <= 3'd0;
         r_plot   <= 1'b0;
         r_start  <= 1'b0;
         r_selout <= 2'd0;
         r_busy   <= 1'b0;
      end else begin
         r_posx   <= w_posx;
         r_posy   <= w_posy;
         r_colour <= w_colour;
         r_plot   <= w_plot;
         r_start  <= w_start;
         r_busy   <= (w_next != S_IDLE);
         if (w_grant_img) r_selout <= r_sel;
      end
   end

   assign bus.posXout   = r_posx;
   assign bus.posYout   = r_posy;
   assign bus.colourOut = r_colour;
   assign bus.plotEn    = r_plot;
   assign bus.imgStart  = r_start;
   assign bus.imgSelOut = r_selout;
   assign bus.sqFull    = r_full;
   assign bus.sqDropped = r_dropped;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: square expansion, queue full/drop,
// image forwarding, arbitration ties, off-screen squares and mid-job reset.
module tb_draw_scheduler;
   logic clk = 1'b0;
   logic Reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   draw_scheduler_if bus();

   draw_scheduler #(
      .FIFO_DEPTH(4),
      .ORIGIN_X0 (26),
      .ORIGIN_X1 (90),
      .ORIGIN_Y  (36),
      .PITCH     (5)
   ) dut (
      .clk  (clk),
      .Reset(Reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.sqReq = 1'b0; bus.sqX = 4'd0; bus.sqY = 4'd0; bus.sqBoard = 1'b0;
      bus.sqColour = 3'd0; bus.imgReq = 1'b0; bus.imgSel = 2'd0;
      bus.imgX = 8'd0; bus.imgY = 7'd0; bus.imgColour = 3'd0;
      bus.imgValid = 1'b0; bus.imgDone = 1'b0;
   endtask

   task automatic push_sq(input logic b, input logic [3:0] x, input logic [3:0] y,
                          input logic [2:0] c);
      bus.sqReq = 1'b1; bus.sqBoard = b; bus.sqX = x; bus.sqY = y; bus.sqColour = c;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
   endtask

   // Observe n consecutive square pixels starting at (x0, y0), row-major
   task automatic sq_pixels(input string tag, input int x0, input int y0,
                            input logic [2:0] c, input logic plot, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.sqReq = 1'b0; bus.imgReq = 1'b0;
         check({tag, ".plot"}, 32'(bus.plotEn), 32'(plot));
         check({tag, ".x"}, 32'(bus.posXout), 32'(x0 + k % 4));
         check({tag, ".y"}, 32'(bus.posYout), 32'(y0 + k / 4));
         check({tag, ".c"}, 32'(bus.colourOut), 32'(c));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".plotEn"},    32'(bus.plotEn), 32'd0);
      check({tag, ".posX"},      32'(bus.posXout), 32'd0);
      check({tag, ".posY"},      32'(bus.posYout), 32'd0);
      check({tag, ".colour"},    32'(bus.colourOut), 32'd0);
      check({tag, ".imgStart"},  32'(bus.imgStart), 32'd0);
      check({tag, ".imgSelOut"}, 32'(bus.imgSelOut), 32'd0);
      check({tag, ".sqFull"},    32'(bus.sqFull), 32'd0);
      check({tag, ".sqDropped"}, 32'(bus.sqDropped), 32'd0);
      check({tag, ".busy"},      32'(bus.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded budget", $time);
      $fatal(1);
   end

   logic       qb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [3:0] qx [4] = '{4'd0, 4'd1, 4'd9, 4'd5};
   logic [3:0] qy [4] = '{4'd0, 4'd0, 4'd9, 4'd2};
   int         ex [4] = '{26, 95, 71, 115};
   int         ey [4] = '{36, 36, 81, 46};

   initial begin
      idle_inputs();
      Reset = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      Reset = 1'b0;

      // Basic square: board 0, cell (2,3) -> x 36..39, y 51..54
      @(negedge clk); push_sq(1'b0, 4'd2, 4'd3, 3'b100);
      @(negedge clk); bus.sqReq = 1'b0;
      check("t2.lat0.plot", 32'(bus.plotEn), 32'd0);
      check("t2.lat0.busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("t2.lat1.plot", 32'(bus.plotEn), 32'd0);
      check("t2.lat1.busy", 32'(bus.busy), 32'd1);
      sq_pixels("t2", 36, 51, 3'b100, 1'b1, 16);
      @(negedge clk);
      check("t2.end.plot", 32'(bus.plotEn), 32'd0);
      check("t2.end.busy", 32'(bus.busy), 32'd0);

      // Tie after reset: square first, then image sel 2
      do_reset();
      @(negedge clk); push_sq(1'b0, 4'd0, 4'd0, 3'd1); bus.imgReq = 1'b1; bus.imgSel = 2'd2;
      @(negedge clk); bus.sqReq = 1'b0; bus.imgReq = 1'b0;
      @(negedge clk);
      check("t3.grant.busy", 32'(bus.busy), 32'd1);
      check("t3.grant.start", 32'(bus.imgStart), 32'd0);
      sq_pixels("t3sq", 26, 36, 3'd1, 1'b1, 16);
      @(negedge clk);
      check("t3.start", 32'(bus.imgStart), 32'd1);
      check("t3.selout", 32'(bus.imgSelOut), 32'd2);
      check("t3.start.plot", 32'(bus.plotEn), 32'd0);
      check("t3.start.busy", 32'(bus.busy), 32'd1);
      bus.imgValid = 1'b1; bus.imgX = 8'd10; bus.imgY = 7'd20; bus.imgColour = 3'd5;
      @(negedge clk);
      check("t3.px0.plot", 32'(bus.plotEn), 32'd1);
      check("t3.px0.x", 32'(bus.posXout), 32'd10);
      check("t3.px0.y", 32'(bus.posYout), 32'd20);
      check("t3.px0.c", 32'(bus.colourOut), 32'd5);
      check("t3.start.pulse", 32'(bus.imgStart), 32'd0);
      bus.imgValid = 1'b0; bus.imgX = 8'd99;
      @(negedge clk);
      check("t3.gap.plot", 32'(bus.plotEn), 32'd0);
      bus.imgValid = 1'b1; bus.imgX = 8'd11; bus.imgY = 7'd21; bus.imgColour = 3'd6;
      bus.imgDone = 1'b1;
      @(negedge clk);
      check("t3.last.plot", 32'(bus.plotEn), 32'd1);
      check("t3.last.x", 32'(bus.posXout), 32'd11);
      check("t3.last.y", 32'(bus.posYout), 32'd21);
      check("t3.last.c", 32'(bus.colourOut), 32'd6);
      check("t3.last.busy", 32'(bus.busy), 32'd0);
      idle_inputs();
      @(negedge clk);
      check("t3.idle.plot", 32'(bus.plotEn), 32'd0);
      check("t3.idle.selout", 32'(bus.imgSelOut), 32'd2);

      // Two image requests while a square runs: one job, latest select wins
      @(negedge clk); push_sq(1'b1, 4'd0, 4'd1, 3'd2);
      @(negedge clk); bus.sqReq = 1'b0; bus.imgReq = 1'b1; bus.imgSel = 2'd0;
      @(negedge clk); bus.imgSel = 2'd1;
      check("t4.busy", 32'(bus.busy), 32'd1);
      sq_pixels("t4sq", 90, 41, 3'd2, 1'b1, 16);
      @(negedge clk);
      check("t4.start", 32'(bus.imgStart), 32'd1);
      check("t4.selout", 32'(bus.imgSelOut), 32'd1);
      bus.imgDone = 1'b1;
      @(negedge clk);
      bus.imgDone = 1'b0;
      check("t4.done.busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4.nojob.start", 32'(bus.imgStart), 32'd0);
         check("t4.nojob.busy", 32'(bus.busy), 32'd0);
      end

      // Queue fills while an image job holds the port; 5th request drops
      do_reset();
      @(negedge clk); bus.imgReq = 1'b1; bus.imgSel = 2'd0;
      @(negedge clk); bus.imgReq = 1'b0;
      @(negedge clk);
      check("t5.img.start", 32'(bus.imgStart), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) push_sq(qb[i], qx[i], qy[i], 3'(i + 1));
         else       push_sq(1'b0, 4'd7, 4'd7, 3'd5);
         @(negedge clk);
         check("t5.full", 32'(bus.sqFull), 32'(i >= 3));
         check("t5.dropped", 32'(bus.sqDropped), 32'(i == 4));
      end
      bus.sqReq = 1'b0;
      @(negedge clk);
      check("t5.dropped.pulse", 32'(bus.sqDropped), 32'd0);
      check("t5.full.hold", 32'(bus.sqFull), 32'd1);
      check("t5.img.plot", 32'(bus.plotEn), 32'd0);
      bus.imgDone = 1'b1;
      @(negedge clk);
      bus.imgDone = 1'b0;
      check("t5.done.busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("t5.pop.full", 32'(bus.sqFull), 32'd0);
      check("t5.pop.busy", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk);
            check("t5.gap.plot", 32'(bus.plotEn), 32'd0);
         end
         sq_pixels("t5sq", ex[i], ey[i], 3'(i + 1), 1'b1, 16);
      end
      repeat (2) begin
         @(negedge clk);
         check("t5.end.busy", 32'(bus.busy), 32'd0);
         check("t5.end.plot", 32'(bus.plotEn), 32'd0);
      end

      // Off-screen square on board 1, cell (15,15): x 165..168
      @(negedge clk); push_sq(1'b1, 4'd15, 4'd15, 3'd3);
      @(negedge clk); bus.sqReq = 1'b0;
      @(negedge clk);
      check("t6.busy", 32'(bus.busy), 32'd1);
      sq_pixels("t6", 165, 111, 3'd3, 1'b0, 16);
      @(negedge clk);
      check("t6.end.busy", 32'(bus.busy), 32'd0);

      // Reset with cnt = 7 mid-square, then a fresh square
      @(negedge clk); push_sq(1'b0, 4'd4, 4'd4, 3'd6);
      @(negedge clk); bus.sqReq = 1'b0;
      @(negedge clk);
      sq_pixels("t7a", 46, 56, 3'd6, 1'b1, 7);
      Reset = 1'b1;
      @(negedge clk);
      check_all_zero("t7rst");
      Reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("t7.post.plot", 32'(bus.plotEn), 32'd0);
         check("t7.post.busy", 32'(bus.busy), 32'd0);
      end
      push_sq(1'b0, 4'd1, 4'd1, 3'd2);
      @(negedge clk); bus.sqReq = 1'b0;
      @(negedge clk);
      check("t7b.busy", 32'(bus.busy), 32'd1);
      sq_pixels("t7b", 31, 41, 3'd2, 1'b1, 16);
      @(negedge clk);
      check("t7b.end.busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
